// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for a 5-stage RV32I pipeline.
// Tracks the destinations held in EX, MEM and WB in a shadow record. From that
// record it drives the pipeline enables, bubbles and flushes and the operand
// forwarding selects. It also sequences data-memory waits and the ECALL halt.
// Build option: define FORWARDING_EN to enable operand forwarding. Without it,
// every in-flight RAW dependency stalls until the producer has left WB.
module pipeline_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] id_rd_addr,
  input  logic       id_rd_wen,
  input  logic       id_is_load,
  input  logic       id_is_mem,
  input  logic       id_ecall,
  input  logic       ex_br_taken,
  input  logic       dmem_ready,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       pipe_en,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       halt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       rd_wen;
    logic       is_load;
    logic       is_mem;
    logic       ecall;
  } shadow_t;

  state_t  state_r;
  state_t  state_nxt_s;
  shadow_t ex_r;
  shadow_t mem_r;
  shadow_t wb_r;
  shadow_t id_entry_s;

  logic ex_rs1_s, ex_rs2_s;
  logic mem_rs1_s, mem_rs2_s;
  logic wb_rs1_s, wb_rs2_s;
  logic mem_wait_s;
  logic stall_s;
  logic retire_ecall_s;
  logic id_adv_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;
  logic unused_ok_s;

  // A shadow entry produces a source operand only if it really writes a
  // non-zero register that the ID instruction actually reads.
  function automatic logic match_f(input shadow_t e, input logic [4:0] src, input logic used);
    return e.valid & e.rd_wen & (e.rd != 5'd0) & (e.rd == src) & used;
  endfunction

  assign id_entry_s = '{valid:   id_valid,
                        rd:      id_rd_addr,
                        rd_wen:  id_rd_wen,
                        is_load: id_is_load,
                        is_mem:  id_is_mem,
                        ecall:   id_ecall};

  assign ex_rs1_s  = match_f(ex_r,  id_rs1_addr, id_rs1_used);
  assign ex_rs2_s  = match_f(ex_r,  id_rs2_addr, id_rs2_used);
  assign mem_rs1_s = match_f(mem_r, id_rs1_addr, id_rs1_used);
  assign mem_rs2_s = match_f(mem_r, id_rs2_addr, id_rs2_used);
  assign wb_rs1_s  = match_f(wb_r,  id_rs1_addr, id_rs1_used);
  assign wb_rs2_s  = match_f(wb_r,  id_rs2_addr, id_rs2_used);

  // The MEM-stage access freezes the pipe from the very first not-ready cycle.
  assign mem_wait_s     = mem_r.valid & mem_r.is_mem & ~dmem_ready;
  // The ecall retires from WB only on an edge where the pipe advances.
  assign retire_ecall_s = wb_r.valid & wb_r.ecall & ~mem_wait_s;

`ifdef FORWARDING_EN
  // Only a load still in EX cannot be forwarded; the younger producer wins.
  always_comb begin
    stall_s = (ex_rs1_s | ex_rs2_s) & ex_r.is_load;
    if (mem_rs1_s) begin
      fwd_a_s = 2'd1;
    end else if (wb_rs1_s) begin
      fwd_a_s = 2'd2;
    end else begin
      fwd_a_s = 2'd0;
    end
    if (mem_rs2_s) begin
      fwd_b_s = 2'd1;
    end else if (wb_rs2_s) begin
      fwd_b_s = 2'd2;
    end else begin
      fwd_b_s = 2'd0;
    end
  end
`else
  // Without forwarding, any in-flight producer (WB included) holds ID back.
  always_comb begin
    stall_s = ex_rs1_s | ex_rs2_s | mem_rs1_s | mem_rs2_s | wb_rs1_s | wb_rs2_s;
    fwd_a_s = 2'd0;
    fwd_b_s = 2'd0;
  end
`endif

  // Next-state logic: wait while MEM is not ready, halt once the ecall retires.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN, ST_MEMWAIT: begin
        if (mem_wait_s) begin
          state_nxt_s = ST_MEMWAIT;
        end else if (retire_ecall_s) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // Pipeline control outputs, prioritised halt > memory wait > branch > stall.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_en      = 1'b0;
    fwd_a        = 2'd0;
    fwd_b        = 2'd0;
    case (state_r)
      ST_RUN, ST_MEMWAIT: begin
        fwd_a = fwd_a_s;
        fwd_b = fwd_b_s;
        if (mem_wait_s) begin
          pc_en = 1'b0;
        end else if (ex_br_taken) begin
          pc_en        = 1'b1;
          if_id_en     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          pipe_en      = 1'b1;
        end else if (stall_s) begin
          id_ex_bubble = 1'b1;
          pipe_en      = 1'b1;
        end else begin
          pc_en    = 1'b1;
          if_id_en = 1'b1;
          pipe_en  = 1'b1;
        end
      end
      ST_HALT: begin
        pc_en = 1'b0;
      end
      default: begin
        pc_en = 1'b0;
      end
    endcase
  end

  assign id_adv_s = pipe_en & ~id_ex_bubble;
  assign halt     = (state_r == ST_HALT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Shadow pipeline: advances with pipe_en; EX takes ID or a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r  <= '0;
      mem_r <= '0;
      wb_r  <= '0;
    end else if (pipe_en) begin
      wb_r  <= mem_r;
      mem_r <= ex_r;
      if (id_adv_s) begin
        ex_r <= id_entry_s;
      end else begin
        ex_r <= '0;
      end
    end else begin
      ex_r  <= ex_r;
      mem_r <= mem_r;
      wb_r  <= wb_r;
    end
  end

  assign unused_ok_s = ^{wb_r.is_load, wb_r.is_mem};

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl. The expected values follow
// the FORWARDING_EN setting used to build the design.
module tb_pipeline_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1_addr;
  logic [4:0] id_rs2_addr;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] id_rd_addr;
  logic       id_rd_wen;
  logic       id_is_load;
  logic       id_is_mem;
  logic       id_ecall;
  logic       ex_br_taken;
  logic       dmem_ready;
  logic       pc_en;
  logic       if_id_en;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic       pipe_en;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       halt;

  int checks_cnt;
  int fail_cnt;

  // Output control patterns {pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en}
  localparam logic [4:0] C_N = 5'b11001;  // normal flow
  localparam logic [4:0] C_S = 5'b00011;  // stall with bubble
  localparam logic [4:0] C_F = 5'b11111;  // branch flush
  localparam logic [4:0] C_W = 5'b00000;  // frozen / halted

  pipeline_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd_addr   (id_rd_addr),
    .id_rd_wen    (id_rd_wen),
    .id_is_load   (id_is_load),
    .id_is_mem    (id_is_mem),
    .id_ecall     (id_ecall),
    .ex_br_taken  (ex_br_taken),
    .dmem_ready   (dmem_ready),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .pipe_en      (pipe_en),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .halt         (halt)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt = checks_cnt + 1;
    if (got !== exp) begin
      fail_cnt = fail_cnt + 1;
      $display("FAIL %s: got=%b expected=%b", tag, got[9:0], exp[9:0]);
    end
  endtask

  function automatic logic [31:0] exp_f(input logic [4:0] ctl, input logic [1:0] fa,
                                        input logic [1:0] fb, input logic h);
    return {22'd0, ctl, fa, fb, h};
  endfunction

  task automatic chk_out(input string tag, input logic [31:0] exp);
    #1;
    check_eq(tag, {22'd0, pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en, fwd_a, fwd_b, halt}, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic wen, input logic ld, input logic mem, input logic ec);
    id_valid    = v;
    id_rs1_addr = rs1;
    id_rs1_used = u1;
    id_rs2_addr = rs2;
    id_rs2_used = u2;
    id_rd_addr  = rd;
    id_rd_wen   = wen;
    id_is_load  = ld;
    id_is_mem   = mem;
    id_ecall    = ec;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    ex_br_taken = 1'b0;
    dmem_ready  = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    checks_cnt  = 0;
    fail_cnt    = 0;
    rst         = 1'b1;
    ex_br_taken = 1'b0;
    dmem_ready  = 1'b1;
    nop();
    step();
    step();
    chk_out("reset", exp_f(C_N, 2'd0, 2'd0, 1'b0));
    rst = 1'b0;
    step();

    // Back-to-back dependency: addi x5,x0,7 ; add x6,x5,x5
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("b2b_addi", exp_f(C_N, 2'd0, 2'd0, 1'b0));
    step();
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef FORWARDING_EN
    chk_out("b2b_add_ex", exp_f(C_N, 2'd0, 2'd0, 1'b0));
    step();
    // sub x7,x5,x6: x5 in MEM, x6 in EX
    set_id(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("b2b_fwd_mem", exp_f(C_N, 2'd1, 2'd0, 1'b0));
    step();
    // or x8,x5,x6: x5 in WB, x6 in MEM
    set_id(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("b2b_fwd_wb_mem", exp_f(C_N, 2'd2, 2'd1, 1'b0));
`else
    chk_out("b2b_stall1", exp_f(C_S, 2'd0, 2'd0, 1'b0));
    step();
    chk_out("b2b_stall2", exp_f(C_S, 2'd0, 2'd0, 1'b0));
    step();
    chk_out("b2b_stall3", exp_f(C_S, 2'd0, 2'd0, 1'b0));
    step();
    chk_out("b2b_release", exp_f(C_N, 2'd0, 2'd0, 1'b0));
`endif
    drain();

    // Load-use: lw x5,0(x1) ; add x6,x5,x0
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    chk_out("lu_lw", exp_f(C_N, 2'd0, 2'd0, 1'b0));
    step();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("lu_stall", exp_f(C_S, 2'd0, 2'd0, 1'b0));
    step();
`ifdef FORWARDING_EN
    chk_out("lu_after", exp_f(C_N, 2'd1, 2'd0, 1'b0));
`else
    chk_out("lu_after", exp_f(C_S, 2'd0, 2'd0, 1'b0));
`endif
    step();
    // add x7,x5,x5 with the load now in WB
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef FORWARDING_EN
    chk_out("lu_wb", exp_f(C_N, 2'd2, 2'd2, 1'b0));
`else
    chk_out("lu_wb", exp_f(C_S, 2'd0, 2'd0, 1'b0));
`endif
    drain();

    // Younger producer wins: two writes of x5, then a reader
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("young_addi2", exp_f(C_N, 2'd0, 2'd0, 1'b0));
    step();
    nop();
    step();
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef FORWARDING_EN
    chk_out("young_wins", exp_f(C_N, 2'd1, 2'd1, 1'b0));
`else
    chk_out("young_wins", exp_f(C_S, 2'd0, 2'd0, 1'b0));
`endif
    drain();

    // x0 destination: addi x0,x0,1 ; add x6,x0,x0
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("x0_dest", exp_f(C_N, 2'd0, 2'd0, 1'b0));
    drain();

    // Taken branch overrides a load-use on the ID instruction
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    ex_br_taken = 1'b1;
    chk_out("br_flush", exp_f(C_F, 2'd0, 2'd0, 1'b0));
    step();
    ex_br_taken = 1'b0;
    // add x10,x9,x0: squashed lw x9 must not linger in EX
    set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("br_ex_cleared", exp_f(C_N, 2'd0, 2'd0, 1'b0));
    drain();

    // Memory wait: sw in MEM with dmem_ready low for 3 cycles
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_out("mw_sw_id", exp_f(C_N, 2'd0, 2'd0, 1'b0));
    step();
    nop();
    step();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    dmem_ready = 1'b0;
`ifdef FORWARDING_EN
    chk_out("mw_wait1", exp_f(C_W, 2'd2, 2'd0, 1'b0));
    step();
    ex_br_taken = 1'b1;
    chk_out("mw_wait2_br", exp_f(C_W, 2'd2, 2'd0, 1'b0));
    step();
    ex_br_taken = 1'b0;
    chk_out("mw_wait3", exp_f(C_W, 2'd2, 2'd0, 1'b0));
    step();
    dmem_ready = 1'b1;
    chk_out("mw_resume", exp_f(C_N, 2'd2, 2'd0, 1'b0));
`else
    chk_out("mw_wait1", exp_f(C_W, 2'd0, 2'd0, 1'b0));
    step();
    ex_br_taken = 1'b1;
    chk_out("mw_wait2_br", exp_f(C_W, 2'd0, 2'd0, 1'b0));
    step();
    ex_br_taken = 1'b0;
    chk_out("mw_wait3", exp_f(C_W, 2'd0, 2'd0, 1'b0));
    step();
    dmem_ready = 1'b1;
    chk_out("mw_resume", exp_f(C_S, 2'd0, 2'd0, 1'b0));
`endif
    drain();

    // Reset in the middle of a load-use stall
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_out("rst_mid_stall_pre", exp_f(C_S, 2'd0, 2'd0, 1'b0));
    rst = 1'b1;
    step();
    chk_out("rst_mid_stall", exp_f(C_N, 2'd0, 2'd0, 1'b0));
    rst = 1'b0;
    drain();

    // ECALL flowing to WB, then halt
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    nop();
    step();
    step();
    chk_out("ecall_in_wb", exp_f(C_N, 2'd0, 2'd0, 1'b0));
    step();
    chk_out("halt_set", exp_f(C_W, 2'd0, 2'd0, 1'b1));
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    ex_br_taken = 1'b1;
    step();
    chk_out("halt_hold", exp_f(C_W, 2'd0, 2'd0, 1'b1));
    ex_br_taken = 1'b0;
    nop();
    rst = 1'b1;
    step();
    chk_out("halt_rst", exp_f(C_N, 2'd0, 2'd0, 1'b0));
    rst = 1'b0;
    step();
    chk_out("halt_after_rst", exp_f(C_N, 2'd0, 2'd0, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
